// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks the captured operands MSB first,
// one bit per clock, and reports lt/gt/eq with a one-cycle done pulse.
//
// Parameters:
//   WIDTH      operand width in bits (2..32)
//   EARLY_EXIT 1: stop at the first differing bit; 0: always WIDTH cycles
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      compare request, accepted in IDLE or DONE
//   is_signed  two's complement operands (captured with start)
//   A, B       operands (captured with start)
//   busy       high while a comparison is running
//   done       one-cycle pulse when lt/gt/eq become valid
//   lt, gt, eq comparison result, held until the next accepted start
module seq_mag_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx;

    // Per-bit decision for the bit currently under the index
    logic bit_a;
    logic bit_b;
    logic diff;
    logic at_msb;
    logic at_lsb;
    logic a_wins;
    logic found;

    always_comb begin
        bit_a  = a_q[idx];
        bit_b  = b_q[idx];
        diff   = bit_a ^ bit_b;
        at_msb = (idx == IW'(WIDTH - 1));
        at_lsb = (idx == '0);
        // The sign bit carries inverted weight for two's complement operands
        a_wins = (at_msb && sgn_q) ? ~bit_a : bit_a;
        // A decision already latched (only reachable when EARLY_EXIT=0)
        found  = lt | gt;
    end

    // State, captured operands, bit index and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        a_q   <= A;
                        b_q   <= B;
                        sgn_q <= is_signed;
                        idx   <= IW'(WIDTH - 1);
                        busy  <= 1'b1;
                        lt    <= 1'b0;
                        gt    <= 1'b0;
                        eq    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    // Only the first difference decides the result
                    if (!found && diff) begin
                        gt <= a_wins;
                        lt <= ~a_wins;
                    end
                    if ((EARLY_EXIT && diff) || at_lsb) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        eq    <= ~found & ~diff;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator at WIDTH=4: instance e0 uses
// EARLY_EXIT=1, instance e1 uses EARLY_EXIT=0; operands are shared.
module tb_seq_mag_comparator;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start0;
    logic         start1;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy0, done0, lt0, gt0, eq0;
    logic         busy1, done1, lt1, gt1, eq1;

    int n_cmp;
    int n_bad;

    seq_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) e0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .is_signed(is_signed),
        .A(a), .B(b), .busy(busy0), .done(done0), .lt(lt0), .gt(gt0), .eq(eq0)
    );

    seq_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) e1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .is_signed(is_signed),
        .A(a), .B(b), .busy(busy1), .done(done1), .lt(lt1), .gt(gt1), .eq(eq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of one instance packed as {lt,gt,eq}
    function automatic logic [2:0] res(input bit inst);
        return inst ? {lt1, gt1, eq1} : {lt0, gt0, eq0};
    endfunction

    function automatic logic sel_busy(input bit inst);
        return inst ? busy1 : busy0;
    endfunction

    function automatic logic sel_done(input bit inst);
        return inst ? done1 : done0;
    endfunction

    // Issue one compare on an instance; k = edges from accept to done
    // (99 on timeout), nb = negedge samples with busy=1 before done.
    task automatic run_cmp(input bit inst, input logic sgn, input logic [W-1:0] av,
                           input logic [W-1:0] bv, output int k, output int nb);
        @(negedge clk);
        is_signed = sgn;
        a = av;
        b = bv;
        if (inst) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(inst, k, nb);
    endtask

    // Called at the negedge right after the accepting edge
    task automatic wait_done(input bit inst, output int k, output int nb);
        k  = 99;
        nb = sel_busy(inst) ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sel_done(inst)) begin
                k = i;
                break;
            end
            if (sel_busy(inst)) nb++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start0 = 1'b1;
        start1 = 1'b1;
        is_signed = 1'b0;
        a = 4'b0001;
        b = 4'b0010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy0, done0, lt0, gt0, eq0} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_e0 got %b want 00000", {busy0, done0, lt0, gt0, eq0});
        end
        n_cmp++;
        if ({busy1, done1, lt1, gt1, eq1} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_e1 got %b want 00000", {busy1, done1, lt1, gt1, eq1});
        end
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_unsigned_early();
        int k, nb;
        run_cmp(1'b0, 1'b0, 4'b1000, 4'b0111, k, nb);
        n_cmp++;
        if (k !== 1) begin n_bad++; $display("FAIL ue_latency got %0d want 1", k); end
        n_cmp++;
        if (res(1'b0) !== 3'b010) begin n_bad++; $display("FAIL ue_result got %b want 010", res(1'b0)); end
        n_cmp++;
        if (busy0 !== 1'b0) begin n_bad++; $display("FAIL ue_busy_at_done got %b want 0", busy0); end
        @(negedge clk);
        n_cmp++;
        if ({done0, res(1'b0)} !== 4'b0010) begin
            n_bad++;
            $display("FAIL ue_pulse_hold got %b want 0010", {done0, res(1'b0)});
        end
    endtask

    task automatic test_equal();
        int k, nb;
        run_cmp(1'b0, 1'b0, 4'b1010, 4'b1010, k, nb);
        n_cmp++;
        if (k !== 4) begin n_bad++; $display("FAIL eq_latency got %0d want 4", k); end
        n_cmp++;
        if (nb !== 4) begin n_bad++; $display("FAIL eq_busy_cycles got %0d want 4", nb); end
        n_cmp++;
        if (res(1'b0) !== 3'b001) begin n_bad++; $display("FAIL eq_result got %b want 001", res(1'b0)); end
    endtask

    task automatic test_signed();
        int k, nb;
        run_cmp(1'b0, 1'b1, 4'b1111, 4'b0001, k, nb);
        n_cmp++;
        if ({k, res(1'b0)} !== {32'd1, 3'b100}) begin
            n_bad++;
            $display("FAIL sgn_m1_vs_1 got k=%0d r=%b want k=1 r=100", k, res(1'b0));
        end
        run_cmp(1'b0, 1'b0, 4'b1111, 4'b0001, k, nb);
        n_cmp++;
        if ({k, res(1'b0)} !== {32'd1, 3'b010}) begin
            n_bad++;
            $display("FAIL uns_15_vs_1 got k=%0d r=%b want k=1 r=010", k, res(1'b0));
        end
        // 7 > -8 decided at the sign bit
        run_cmp(1'b0, 1'b1, 4'b0111, 4'b1000, k, nb);
        n_cmp++;
        if ({k, res(1'b0)} !== {32'd1, 3'b010}) begin
            n_bad++;
            $display("FAIL sgn_7_vs_m8 got k=%0d r=%b want k=1 r=010", k, res(1'b0));
        end
        // -2 < -1, only bit 0 differs
        run_cmp(1'b0, 1'b1, 4'b1110, 4'b1111, k, nb);
        n_cmp++;
        if ({k, res(1'b0)} !== {32'd4, 3'b100}) begin
            n_bad++;
            $display("FAIL sgn_m2_vs_m1 got k=%0d r=%b want k=4 r=100", k, res(1'b0));
        end
    endtask

    task automatic test_const_time();
        int k, nb;
        run_cmp(1'b1, 1'b0, 4'b1000, 4'b0000, k, nb);
        n_cmp++;
        if ({k, res(1'b1)} !== {32'd4, 3'b010}) begin
            n_bad++;
            $display("FAIL ct_8_vs_0 got k=%0d r=%b want k=4 r=010", k, res(1'b1));
        end
        // Later bits favour B but the first difference must stick
        run_cmp(1'b1, 1'b0, 4'b1000, 4'b0111, k, nb);
        n_cmp++;
        if ({k, res(1'b1)} !== {32'd4, 3'b010}) begin
            n_bad++;
            $display("FAIL ct_latch got k=%0d r=%b want k=4 r=010", k, res(1'b1));
        end
        run_cmp(1'b1, 1'b1, 4'b1000, 4'b0111, k, nb);
        n_cmp++;
        if ({k, nb, res(1'b1)} !== {32'd4, 32'd4, 3'b100}) begin
            n_bad++;
            $display("FAIL ct_signed got k=%0d nb=%0d r=%b want k=4 nb=4 r=100", k, nb, res(1'b1));
        end
        run_cmp(1'b1, 1'b0, 4'b0110, 4'b0110, k, nb);
        n_cmp++;
        if ({k, res(1'b1)} !== {32'd4, 3'b001}) begin
            n_bad++;
            $display("FAIL ct_equal got k=%0d r=%b want k=4 r=001", k, res(1'b1));
        end
    endtask

    task automatic test_ignore_start();
        int k, nb;
        @(negedge clk);
        is_signed = 1'b0;
        a = 4'b0001;
        b = 4'b0010;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Second request while busy must not disturb the captured operands
        a = 4'b1111;
        b = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        wait_done(1'b0, k, nb);
        n_cmp++;
        if ({k, res(1'b0)} !== {32'd2, 3'b100}) begin
            n_bad++;
            $display("FAIL ignore_start got k=%0d r=%b want k=2 r=100", k, res(1'b0));
        end
    endtask

    task automatic test_back_to_back();
        int k, nb;
        run_cmp(1'b0, 1'b0, 4'b1000, 4'b0111, k, nb);
        n_cmp++;
        if (k !== 1) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 1", k); end
        // Start sampled during the DONE cycle
        a = 4'b0011;
        b = 4'b0011;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        n_cmp++;
        if ({busy0, done0, res(1'b0)} !== 5'b10000) begin
            n_bad++;
            $display("FAIL b2b_accept got %b want 10000", {busy0, done0, res(1'b0)});
        end
        wait_done(1'b0, k, nb);
        n_cmp++;
        if ({k, res(1'b0)} !== {32'd4, 3'b001}) begin
            n_bad++;
            $display("FAIL b2b_second got k=%0d r=%b want k=4 r=001", k, res(1'b0));
        end
    endtask

    task automatic test_reset_mid_run();
        int k, nb;
        int pulses;
        @(negedge clk);
        is_signed = 1'b0;
        a = 4'b0000;
        b = 4'b0001;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy0, done0, lt0, gt0, eq0} !== 5'b0) begin
            n_bad++;
            $display("FAIL midrun_reset got %b want 00000", {busy0, done0, lt0, gt0, eq0});
        end
        // Start held during reset must be ignored
        start0 = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 || busy0) pulses++;
        end
        start0 = 1'b0;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done0 || busy0) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin n_bad++; $display("FAIL midrun_no_done got %0d activity want 0", pulses); end
        run_cmp(1'b0, 1'b0, 4'b0011, 4'b0011, k, nb);
        n_cmp++;
        if ({k, res(1'b0)} !== {32'd4, 3'b001}) begin
            n_bad++;
            $display("FAIL post_reset_eq got k=%0d r=%b want k=4 r=001", k, res(1'b0));
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_unsigned_early();
        test_equal();
        test_signed();
        test_const_time();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
